multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the processor datapath; the control-side counterpart of the ALU.
- Sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal.
- Drives the datapath mux selects and write enables, and produces the 4-bit ALU operation code from op/funct3/funct7b5.
- Stalls on a memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  opcode from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  0=PC, 1=ALUOut as memory address
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register enable
- result_src  out  2  00=ALUOut, 01=read data, 10=ALU result
- alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4
- imm_src  out  2  00=I, 01=S, 10=B, 11=J
- reg_write  out  1  register file write enable
- alucontrol  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT
- illegal  out  1  sticky illegal-instruction flag
- instret  out  CNT_W  retired instruction count

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=FETCH, instret=0.
  - Write enables forced low while reset is asserted: pc_write, ir_write, mem_write, reg_write.
  - illegal=0.
- Outputs are a Moore decode of state, except:
  - pc_write/ir_write in FETCH and pc_write in BEQ.
  - alucontrol in EXECUTER/EXECUTEI, which decodes the instruction fields.
- Unlisted outputs are 0 in every state.
- imm_src is a pure function of op in all states: lw/ALU-I→00, sw→01, beq→10, jal→11, other→00.
- FETCH:
  - adr_src=0, alu_src_a=00, alu_src_b=10, ADD, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Hold while mem_ready=0; →DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=01, alu_src_b=01, ADD (branch target into ALUOut).
  - Next state by op: lw/sw→MEMADR; 0110011→EXECUTER; 0010011→EXECUTEI; 1100011→BEQ; 1101111→JAL.
  - Unknown op, or ALU funct3 not in {000,010,110,111}, or beq funct3≠000 → ERROR.
- MEMADR: alu_src_a=10, alu_src_b=01, ADD; →MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: adr_src=1; →MEMWB on mem_ready, else hold.
- MEMWB: result_src=01, reg_write=1; →FETCH.
- MEMWRITE: adr_src=1, mem_write=1 held every cycle until mem_ready; →FETCH on mem_ready.
- EXECUTER: alu_src_a=10, alu_src_b=00; →ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01; →ALUWB.
- ALUWB: result_src=00, reg_write=1; →FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, SUB, result_src=00, pc_write=zero; →FETCH.
- JAL: alu_src_a=01, alu_src_b=10, ADD, result_src=00, pc_write=1; →ALUWB.
- ERROR:
  - All enables 0; illegal=1.
  - Stays in ERROR until reset.
- ALU decode:
  - funct3 000 → ADD, except R-type with funct7b5=1 → SUB (I-type 000 is always ADD).
  - 010 → SLT, 110 → OR, 111 → AND.
  - Outside EXECUTE states, alucontrol is fixed per state as listed above.
- instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - The counter wraps modulo 2^CNT_W.
  - JAL retires via ALUWB.
- Cycle counts with mem_ready always 1:
  - lw 5, sw 4, R/I 4, beq 3, jal 4.
  - Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset mid-instruction: state returns to FETCH immediately; no enable glitches during reset.

Decomposition:
- Shared package holds:
  - state enum;
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL);
  - alucontrol constants;
  - mux-select constants for result_src, alu_src_a, alu_src_b and imm_src.
- One sub-module, alu_decoder: purely combinational, takes op/funct3/funct7b5 and produces alucontrol plus an illegal-funct flag.

Test Plan:
- Reset then add (op=0110011, f3=000, f7b5=0), mem_ready=1 → states FETCH, DECODE, EXECUTER, ALUWB; alucontrol=0010 in EXECUTER; reg_write=1 only in ALUWB; instret=1.
- sub (f7b5=1), then addi (op=0010011, f7b5=1) → SUB (0110) for sub; addi gives ADD (0010) despite f7b5=1.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMREAD → ir_write/pc_write pulse only on the ready cycle; total 10 cycles; result_src=01 in MEMWB.
- sw with mem_ready=0 for 2 cycles → mem_write high 3 consecutive cycles, then FETCH; reg_write never 1.
- beq with zero=1, then beq with zero=0 → pc_write=1 and 0 respectively in BEQ; jal → pc_write=1 in JAL, reg_write=1 in ALUWB; instret=3.
- op=0000000 → ERROR after DECODE, illegal=1, all enables 0 for 20 cycles; assert rst_n=0 mid-way → state FETCH, illegal=0, instret=0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle control FSM and its ALU decoder.
// Opcode, ALU operation and datapath mux-select values live here so both files agree.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from op/funct3/funct7b5; purely combinational, zero latency.
// illegal_funct flags an unsupported funct3 for ALU ops or a non-beq branch.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alucontrol,
    output logic       illegal_funct
);

    always_comb begin
        alucontrol    = ALU_ADD;
        illegal_funct = 1'b0;
        case (op)
            OP_R, OP_I: begin
                case (funct3)
                    3'b000: alucontrol = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010: alucontrol = ALU_SLT;
                    3'b110: alucontrol = ALU_OR;
                    3'b111: alucontrol = ALU_AND;
                    default: illegal_funct = 1'b1;
                endcase
            end
            OP_BEQ: begin
                alucontrol    = ALU_SUB;
                illegal_funct = (funct3 != 3'b000);
            end
            default: begin
                alucontrol    = ALU_ADD;
                illegal_funct = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback, one state per cycle.
// Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready; counts retired instructions.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       imm_src,
    output logic             reg_write,
    output logic [3:0]       alucontrol,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        dec_alucontrol;
    logic              dec_illegal_funct;
    logic              pc_write_c, ir_write_c, mem_write_c, reg_write_c;
    logic              retire;

    alu_decoder u_alu_decoder (
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .alucontrol    (dec_alucontrol),
        .illegal_funct (dec_illegal_funct)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (dec_illegal_funct) begin
                    state_d = S_ERROR;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_R:         state_d = S_EXECUTER;
                        OP_I:         state_d = S_EXECUTEI;
                        OP_BEQ:       state_d = S_BEQ;
                        OP_JAL:       state_d = S_JAL;
                        default:      state_d = S_ERROR;
                    endcase
                end
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_FETCH;
        endcase
    end

    // JAL is not listed here: it retires on its way through ALUWB.
    assign retire = (state_d == S_FETCH) &&
                    (state_q == S_MEMWB || state_q == S_MEMWRITE ||
                     state_q == S_ALUWB || state_q == S_BEQ);

    assign instret_d = retire ? instret_q + {{(CNT_W-1){1'b0}}, 1'b1} : instret_q;
    assign illegal_d = illegal_q | (state_d == S_ERROR);

    always_comb begin
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alucontrol  = ALU_AND;
        case (state_q)
            S_FETCH: begin
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                alucontrol = ALU_ADD;
                result_src = RES_ALU;
                pc_write_c = mem_ready;
                ir_write_c = mem_ready;
            end
            S_DECODE: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_IMM;
                alucontrol = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alucontrol = ALU_ADD;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = RES_RDATA;
                reg_write_c = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alucontrol = dec_alucontrol;
            end
            S_EXECUTEI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                alucontrol = dec_alucontrol;
            end
            S_ALUWB: begin
                result_src  = RES_ALUOUT;
                reg_write_c = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alucontrol = ALU_SUB;
                result_src = RES_ALUOUT;
                pc_write_c = zero;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                alucontrol = ALU_ADD;
                result_src = RES_ALUOUT;
                pc_write_c = 1'b1;
            end
            default: begin
                pc_write_c = 1'b0;
            end
        endcase
    end

    always_comb begin
        case (op)
            OP_LW, OP_I: imm_src = IMM_I;
            OP_SW:       imm_src = IMM_S;
            OP_BEQ:      imm_src = IMM_B;
            OP_JAL:      imm_src = IMM_J;
            default:     imm_src = IMM_I;
        endcase
    end

    // Reset gates the strobes directly so no enable can glitch while rst_n is low.
    assign pc_write  = rst_n & pc_write_c;
    assign ir_write  = rst_n & ir_write_c;
    assign mem_write = rst_n & mem_write_c;
    assign reg_write = rst_n & reg_write_c;

    assign illegal = illegal_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and random instruction streams against a cycle-list reference model.
module tb_multicycle_controller;

    localparam int CNT_W = 4;
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic             zero;
    logic             mem_ready;
    logic             pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]       result_src, alu_src_a, alu_src_b, imm_src;
    logic [3:0]       alucontrol;
    logic [CNT_W-1:0] instret;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic [1:0] res;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] imm;
        logic       regw;
        logic [3:0] aluc;
        logic       ill;
    } vec_t;

    vec_t obs;
    assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                  alu_src_b, imm_src, reg_write, alucontrol, illegal};

    int               n_cmp = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] exp_cnt;
    vec_t             exp_q[$];
    logic             rdy_q[$];

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .reg_write  (reg_write),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] imm, input logic pcw, input logic adr,
                                input logic memw, input logic irw, input logic [1:0] res,
                                input logic [1:0] a, input logic [1:0] b, input logic regw,
                                input logic [3:0] aluc, input logic ill);
        vec_t t;
        t.pcw = pcw; t.adr = adr; t.memw = memw; t.irw = irw; t.res = res;
        t.a = a; t.b = b; t.imm = imm; t.regw = regw; t.aluc = aluc; t.ill = ill;
        return t;
    endfunction

    function automatic logic [6:0] op_of(input int k);
        case (k)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_BEQ:   return 7'b1100011;
            default: return 7'b1101111;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(input int k);
        case (k)
            K_SW:    return 2'b01;
            K_BEQ:   return 2'b10;
            K_JAL:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input bit is_r, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (is_r && f7) ? 4'b0110 : 4'b0010;
            3'b010:  return 4'b0111;
            3'b110:  return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic push(input vec_t v, input logic r);
        exp_q.push_back(v);
        rdy_q.push_back(r);
    endtask

    task automatic push_front_end(input logic [1:0] im, input int fst);
        for (int i = 0; i < fst; i++)
            push(mk(im, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 4'b0010, 0), 1'b0);
        push(mk(im, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, 4'b0010, 0), 1'b1);
        push(mk(im, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 4'b0010, 0), 1'($urandom));
    endtask

    task automatic play(input string tag);
        int c = 0;
        while (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            mem_ready = rdy_q.pop_front();
            #1;
            check($sformatf("%s cyc%0d", tag, c), 32'(obs), 32'(e));
            c++;
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 with the next FETCH cycle about to start.
    task automatic run_instr(input string tag, input int k, input logic [2:0] f3,
                             input logic f7, input logic z, input int fst, input int mst);
        logic [1:0] im;
        im = imm_of(k);
        op = op_of(k); funct3 = f3; funct7b5 = f7; zero = z;
        check({tag, " instret"}, 32'(instret), 32'(exp_cnt));
        push_front_end(im, fst);
        case (k)
            K_LW: begin
                push(mk(im, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 4'b0010, 0), 1'($urandom));
                for (int i = 0; i < mst; i++)
                    push(mk(im, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0), 1'b0);
                push(mk(im, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0), 1'b1);
                push(mk(im, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 4'b0000, 0), 1'($urandom));
            end
            K_SW: begin
                push(mk(im, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 4'b0010, 0), 1'($urandom));
                for (int i = 0; i < mst; i++)
                    push(mk(im, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0), 1'b0);
                push(mk(im, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 0), 1'b1);
            end
            K_R, K_I: begin
                push(mk(im, 0, 0, 0, 0, 2'b00, 2'b10, (k == K_I) ? 2'b01 : 2'b00, 0,
                        alu_of(k == K_R, f3, f7), 0), 1'($urandom));
                push(mk(im, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 4'b0000, 0), 1'($urandom));
            end
            K_BEQ:
                push(mk(im, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 4'b0110, 0), 1'($urandom));
            default: begin
                push(mk(im, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 4'b0010, 0), 1'($urandom));
                push(mk(im, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 4'b0000, 0), 1'($urandom));
            end
        endcase
        play(tag);
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic run_error(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input int cycles);
        logic [1:0] im;
        im = (o == 7'b1100011) ? 2'b10 : 2'b00;
        op = o; funct3 = f3; funct7b5 = 1'b0; zero = 1'b0;
        push_front_end(im, 0);
        for (int i = 0; i < cycles; i++)
            push(mk(im, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 4'b0000, 1), 1'($urandom));
        play(tag);
        check({tag, " instret held"}, 32'(instret), 32'(exp_cnt));
    endtask

    task automatic do_reset(input string tag);
        logic [1:0] im;
        im = imm_of(K_R);
        op = op_of(K_R); funct3 = 3'b000;
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check({tag, " outputs"}, 32'(obs),
                  32'(mk(im, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 4'b0010, 0)));
            check({tag, " instret"}, 32'(instret), 32'(0));
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    initial begin
        int k;
        logic [2:0] f3;
        logic [2:0] f3_tab [4];
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b010; f3_tab[2] = 3'b110; f3_tab[3] = 3'b111;
        rst_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        exp_cnt = '0;
        @(posedge clk);
        #1;
        do_reset("reset");

        run_instr("add",    K_R,   3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("sub",    K_R,   3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("addi",   K_I,   3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("lw",     K_LW,  3'b010, 1'b0, 1'b0, 2, 3);
        run_instr("sw",     K_SW,  3'b010, 1'b0, 1'b0, 0, 2);
        run_instr("beq_t",  K_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr("beq_nt", K_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("jal",    K_JAL, 3'b000, 1'b0, 1'b0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(0, 5);
            f3 = (k == K_R || k == K_I) ? f3_tab[$urandom_range(0, 3)] :
                 (k == K_BEQ) ? 3'b000 : 3'($urandom);
            run_instr($sformatf("rnd%0d", n), k, f3, 1'($urandom), 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end
        check("instret after stream", 32'(instret), 32'(exp_cnt));

        run_error("badop", 7'b0000000, 3'b000, 20);
        do_reset("reset_in_error");
        run_instr("add_after_reset", K_R, 3'b111, 1'b0, 1'b0, 1, 0);
        run_error("bad_r_f3", 7'b0110011, 3'b001, 5);
        do_reset("reset2");
        run_error("bad_beq_f3", 7'b1100011, 3'b001, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
